// File: rtl/aes_pkg.sv
// Shared AES constants, controller state encoding and the legal lane-count check
// used by the serial SubBytes datapath.
package aes_pkg;

    localparam int STATE_BYTES = 16;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational AES S-box lane: forward table when inv=0, inverse table when inv=1.
module sbox_lane
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] din,
    input  logic              inv,
    output logic [BYTE_W-1:0] dout
);

    // Entry 0 sits in the most significant byte of each table.
    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign dout = inv ? SBOX_INV[din] : SBOX_FWD[din];

endmodule

// File: rtl/subbytes_serial.sv
// Serial AES SubBytes/InvSubBytes: LANES S-boxes process the 16-byte state over
// 16/LANES beats, with an optional register stage after the lanes.
//
// state | meaning
// IDLE  | waiting for a state, in_ready high
// RUN   | one beat of LANES bytes through the lanes per cycle
// DRAIN | PIPE=1 only: last beat leaves the lane register
// DONE  | result valid, held until out_ready
module subbytes_serial
    import aes_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PIPE  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int BEATS = STATE_BYTES / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("subbytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end
    if ((PIPE != 0) && (PIPE != 1)) begin : g_bad_pipe
        $error("subbytes_serial: PIPE must be 0 or 1");
    end

    typedef logic [0:STATE_BYTES-1][BYTE_W-1:0] state_bytes_t;
    typedef logic [LANES-1:0][BYTE_W-1:0]       lane_bytes_t;

    fsm_state_t   state;
    logic [CW-1:0] beat;
    logic         inv_q;
    state_bytes_t src_q;
    state_bytes_t res_q;
    logic [3:0]   base;
    lane_bytes_t  lane_in;
    lane_bytes_t  lane_out;
    logic         wr_en;
    logic [3:0]   wr_base;
    lane_bytes_t  wr_data;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_state = res_q;
    assign base      = 4'(int'(beat) * LANES);

    always_comb begin
        lane_in = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_in[i] = src_q[base + 4'(i)];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_lane u_lane (
            .din  (lane_in[g]),
            .inv  (inv_q),
            .dout (lane_out[g])
        );
    end

    // With the extra stage the write-back trails the lane beat by one cycle.
    if (PIPE == 1) begin : g_pipe
        logic        pv_q;
        logic [3:0]  pbase_q;
        lane_bytes_t pdata_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pv_q    <= 1'b0;
                pbase_q <= '0;
                pdata_q <= '0;
            end else begin
                pv_q    <= (state == ST_RUN);
                pbase_q <= base;
                pdata_q <= lane_out;
            end
        end

        assign wr_en   = pv_q;
        assign wr_base = pbase_q;
        assign wr_data = pdata_q;
    end else begin : g_direct
        assign wr_en   = (state == ST_RUN);
        assign wr_base = base;
        assign wr_data = lane_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                res_q[wr_base + 4'(i)] <= wr_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            beat      <= '0;
            inv_q     <= 1'b0;
            src_q     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        src_q <= in_state;
                        inv_q <= in_inv;
                        beat  <= '0;
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (beat == LAST_BEAT) begin
                        state     <= (PIPE == 1) ? ST_DRAIN : ST_DONE;
                        out_valid <= (PIPE == 0);
                    end else begin
                        beat <= beat + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    state     <= ST_DONE;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            src_q <= in_state;
                            inv_q <= in_inv;
                            beat  <= '0;
                            state <= ST_RUN;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subbytes_serial.sv
// Bench for subbytes_serial: main LANES=4/PIPE=0 instance plus a sweep of every
// LANES/PIPE combination, checked against a GF(2^8)-derived S-box model.
module tb_subbytes_serial;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_inv, out_ready;
    logic [127:0] in_state;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_state;

    logic         sw_in_valid, sw_in_inv, sw_out_ready;
    logic [127:0] sw_in_state;
    logic [9:0]   sw_ir, sw_ov, sw_busy;
    logic [127:0] sw_os [10];

    int checks   = 0;
    int failures = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    subbytes_serial #(.LANES(4), .PIPE(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    // Instance g: LANES = 1 << (g/2), PIPE = g % 2.
    for (genvar g = 0; g < 10; g++) begin : g_sw
        subbytes_serial #(.LANES(1 << (g / 2)), .PIPE(g % 2)) dut_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sw_in_valid),
            .in_ready  (sw_ir[g]),
            .in_state  (sw_in_state),
            .in_inv    (sw_in_inv),
            .out_valid (sw_ov[g]),
            .out_ready (sw_out_ready),
            .out_state (sw_os[g]),
            .busy      (sw_busy[g])
        );
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] v);
        logic [7:0] c = 8'h63;
        logic [7:0] s;
        for (int i = 0; i < 8; i++) begin
            s[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
        end
        return s;
    endfunction

    task automatic build_tables();
        logic [7:0] mi;
        for (int x = 0; x < 256; x++) begin
            mi = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) mi = 8'(y);
            end
            fwd_tab[x] = affine(mi);
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    endtask

    function automatic logic [127:0] subbytes_ref(input logic [127:0] st, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        for (int j = 0; j < 16; j++) begin
            b = st[127 - 8 * j -: 8];
            r[127 - 8 * j -: 8] = inv ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Latency counts the accept edge as cycle 1 up to the edge raising out_valid.
    task automatic run_op(input logic [127:0] st, input logic inv,
                          output logic [127:0] res, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_state  = st;
        in_inv    = inv;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_state = rand128();
        in_inv   = ~inv;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        res = out_state;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags: got rdy/vld/busy=%b expected 100", {in_ready, out_valid, busy});
        end
        checks++;
        if (out_state !== 128'h0) begin
            failures++;
            $display("FAIL reset_out_state: got %h expected 0", out_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || sw_ir !== 10'h3ff) begin
            failures++;
            $display("FAIL post_reset_idle: got rdy/vld/busy=%b sw_ir=%h expected 100/3ff",
                     {in_ready, out_valid, busy}, sw_ir);
        end
    endtask

    task automatic test_fips_vectors();
        logic [127:0] res;
        int lat;
        run_op(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, res, lat);
        checks++;
        if (res !== 128'hd42711aee0bf98f1b8b45de51e415230 || lat !== 5) begin
            failures++;
            $display("FAIL fips_fwd: got %h lat %0d expected d42711aee0bf98f1b8b45de51e415230 lat 5", res, lat);
        end
        run_op(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, res, lat);
        checks++;
        if (res !== 128'h193de3bea0f4e22b9ac68d2ae9f84808 || lat !== 5) begin
            failures++;
            $display("FAIL fips_inv: got %h lat %0d expected 193de3bea0f4e22b9ac68d2ae9f84808 lat 5", res, lat);
        end
    endtask

    task automatic test_random();
        logic [127:0] st, res, exp;
        logic inv;
        int lat;
        for (int n = 0; n < 12; n++) begin
            st  = rand128();
            inv = 1'($urandom_range(0, 1));
            exp = subbytes_ref(st, inv);
            run_op(st, inv, res, lat);
            checks++;
            if (res !== exp || lat !== 5) begin
                failures++;
                $display("FAIL random_op%0d: got %h lat %0d expected %h lat 5 (inv=%0d)", n, res, lat, exp, inv);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] st1, st2, exp1, exp2;
        logic inv1, inv2;
        logic ready_in_run;
        int lat;
        st1 = rand128(); inv1 = 1'($urandom_range(0, 1)); exp1 = subbytes_ref(st1, inv1);
        st2 = rand128(); inv2 = 1'($urandom_range(0, 1)); exp2 = subbytes_ref(st2, inv2);
        @(negedge clk);
        in_valid = 1'b1; in_state = st1; in_inv = inv1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_state !== exp1 || lat !== 5) begin
            failures++;
            $display("FAIL b2b_first: got %h lat %0d expected %h lat 5", out_state, lat, exp1);
        end
        // Offer a different state while stalled; it must not disturb the held result.
        in_valid = 1'b1; in_state = rand128(); in_inv = ~inv2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_state !== exp1 || {out_valid, in_ready, busy} !== 3'b101) begin
                failures++;
                $display("FAIL b2b_stall%0d: got %h vld/rdy/busy=%b expected %h 101",
                         k, out_state, {out_valid, in_ready, busy}, exp1);
            end
        end
        in_state = st2; in_inv = inv2; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_release_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; in_state = rand128();
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b010) begin
            failures++;
            $display("FAIL b2b_second_accept: got vld/busy/rdy=%b expected 010", {out_valid, busy, in_ready});
        end
        lat = 1;
        ready_in_run = 1'b0;
        while (!out_valid && lat < 64) begin
            if (in_ready) ready_in_run = 1'b1;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_state !== exp2 || lat !== 5 || ready_in_run !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: got %h lat %0d rdy_in_run %b expected %h lat 5 rdy 0",
                     out_state, lat, ready_in_run, exp2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            failures++;
            $display("FAIL b2b_return_idle: got vld/busy/rdy=%b expected 001", {out_valid, busy, in_ready});
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] st, res, exp;
        logic seen_valid;
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_state = rand128(); in_inv = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001 || out_state !== 128'h0) begin
            failures++;
            $display("FAIL midrun_reset: got vld/busy/rdy=%b out %h expected 001 out 0",
                     {out_valid, busy, in_ready}, out_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || busy) seen_valid = 1'b1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_result: got activity %b expected 0", seen_valid);
        end
        st = rand128();
        st[127:120] = 8'h53;
        exp = subbytes_ref(st, 1'b0);
        run_op(st, 1'b0, res, lat);
        checks++;
        if (res[127:120] !== 8'hed || res !== exp || lat !== 5) begin
            failures++;
            $display("FAIL midrun_next_op: got %h lat %0d expected %h (byte0 ed) lat 5", res, lat, exp);
        end
    endtask

    task automatic test_sweep(input logic [127:0] st, input logic inv, input logic [127:0] exp);
        int lat [10];
        logic [127:0] res [10];
        logic [9:0] seen;
        int c;
        @(negedge clk);
        checks++;
        if (sw_ir !== 10'h3ff) begin
            failures++;
            $display("FAIL sweep_idle_ready: got %h expected 3ff", sw_ir);
        end
        sw_in_valid = 1'b1; sw_in_state = st; sw_in_inv = inv; sw_out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sw_in_valid = 1'b0; sw_in_state = rand128(); sw_in_inv = ~inv;
        seen = '0;
        c = 1;
        for (int g = 0; g < 10; g++) begin
            lat[g] = 0;
            res[g] = '0;
        end
        while (seen != 10'h3ff && c < 64) begin
            for (int g = 0; g < 10; g++) begin
                if (!seen[g] && sw_ov[g]) begin
                    seen[g] = 1'b1;
                    lat[g]  = c;
                    res[g]  = sw_os[g];
                end
            end
            if (seen != 10'h3ff) begin
                @(negedge clk);
                c++;
            end
        end
        for (int g = 0; g < 10; g++) begin
            checks++;
            if (res[g] !== exp || lat[g] !== 16 / (1 << (g / 2)) + (g % 2) + 1) begin
                failures++;
                $display("FAIL sweep_lanes%0d_pipe%0d: got %h lat %0d expected %h lat %0d",
                         1 << (g / 2), g % 2, res[g], lat[g], exp, 16 / (1 << (g / 2)) + (g % 2) + 1);
            end
        end
        sw_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        sw_out_ready = 1'b0;
        checks++;
        if (sw_busy !== 10'h000 || sw_ov !== 10'h000) begin
            failures++;
            $display("FAIL sweep_release: got busy %h vld %h expected 000 000", sw_busy, sw_ov);
        end
    endtask

    initial begin
        logic [127:0] rst_st;
        logic         rinv;
        rst_n = 1'b0;
        in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_state = '0;
        sw_in_valid = 1'b0; sw_in_inv = 1'b0; sw_out_ready = 1'b0; sw_in_state = '0;
        build_tables();
        test_reset();
        test_fips_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h637c777bf26b6fc53001672bfed7ab76);
        rst_st = rand128();
        rinv = 1'($urandom_range(0, 1));
        test_sweep(rst_st, rinv, subbytes_ref(rst_st, rinv));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
